// File: rtl/gf180mcu_fd_sc_mcu9t5v0__serial_pkg.sv
// Shared types for the bit-serial full-adder datapath.
// State encoding and counter sizing helper.
package gf180mcu_fd_sc_mcu9t5v0__serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must represent 0..WIDTH without wrapping.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__addf_1.sv
// Behavioural model of the library full-adder cell.
// Supply pins are carried through for netlist compatibility.
module gf180mcu_fd_sc_mcu9t5v0__addf_1 (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic S,
    output logic CO,
    inout  wire  VDD,
    inout  wire  VSS
);

    wire unused_pwr = VDD ^ VSS;

    assign S  = A ^ B ^ CI;
    assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__addf_serial.sv
// Bit-serial adder: LSB-first, one bit per clock, carry recirculated
// through a flop around a single full-adder cell.
module gf180mcu_fd_sc_mcu9t5v0__addf_serial
    import gf180mcu_fd_sc_mcu9t5v0__serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] s_sr_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_s;
    logic             fa_co;

    gf180mcu_fd_sc_mcu9t5v0__addf_1 u_fa (
        .A   (a_sr_q[0]),
        .B   (b_sr_q[0]),
        .CI  (carry_q),
        .S   (fa_s),
        .CO  (fa_co),
        .VDD (VDD),
        .VSS (VSS)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        a_sr_q  <= A;
                        b_sr_q  <= B;
                        carry_q <= CI;
                        s_sr_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    // New sum bit enters at the MSB so the LSB lands at bit 0.
                    s_sr_q  <= (s_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign IN_READY  = (state_q == IDLE) & ~RST;
    assign OUT_VALID = (state_q == DONE);
    assign S         = s_sr_q;
    assign CO        = carry_q;

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__addf_serial.md
# gf180mcu_fd_sc_mcu9t5v0__addf_serial

Bit-serial adder built around the library full-adder cell. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It then adds them LSB-first, one bit per clock, recirculating the carry through a flop, and presents the WIDTH-bit sum and carry-out through a second valid/ready handshake. It sits directly downstream of the full-adder cell: it consumes the cell's S/CO every cycle and feeds CO back as the next CI.

## Interface

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range ≥ 1.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset, **synchronous, active-high**.
- IN_VALID  input  1  operands A, B, CI are valid.
- IN_READY  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CI  input  1  initial carry-in.
- OUT_VALID  output  1  S/CO hold a completed result.
- OUT_READY  input  1  downstream takes the result.
- S  output  WIDTH  sum, (A+B+CI) mod 2^WIDTH.
- CO  output  1  final carry-out.
- VDD  inout  1  supply.
- VSS  inout  1  ground.

## Operation

- FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - IN_READY=1.
  - On IN_VALID&IN_READY: load a_sr←A, b_sr←B, carry←CI, cnt←0, s_sr←0; go to RUN.
- **RUN**, one bit per cycle:
  - The full adder takes (a_sr[0], b_sr[0], carry).
  - a_sr and b_sr shift right.
  - s_sr shifts right with the adder S entering at bit WIDTH-1.
  - carry←adder CO; cnt←cnt+1.
  - When cnt==WIDTH-1 at an edge, that edge completes the last bit; go to DONE.
- **DONE**
  - OUT_VALID=1; S=s_sr and CO=carry, both held stable.
  - On OUT_READY: go to IDLE.
- **Ignored inputs**
  - IN_VALID is ignored outside IDLE.
  - OUT_READY is ignored outside DONE.
  - A, B, CI are sampled only at the accept edge; later changes have no effect.
- **Combinational outputs**
  - IN_READY = (state==IDLE) & ~RST.
  - OUT_VALID = (state==DONE).
- **Reset**
  - Any state goes to IDLE.
  - a_sr, b_sr, s_sr, carry and cnt all clear to 0.
  - Reset values: S=0, CO=0, OUT_VALID=0, IN_READY=0 while RST=1 and 1 on the cycle after RST drops.
  - Reset mid-RUN or mid-DONE abandons the operation; no partial result is ever flagged valid.
- **Widths**
  - cnt is $clog2(WIDTH+1) bits and never wraps within an operation.
  - WIDTH=1 is legal: RUN lasts exactly one cycle.

## Timing

- Accept edge k moves the block to RUN.
- RUN occupies edges k+1 … k+WIDTH; the last of these moves it to DONE.
- OUT_VALID is high in the cycle after edge k+WIDTH. Latency is WIDTH cycles from accept to result.
- The handshake edge with OUT_VALID&OUT_READY returns the block to IDLE. IN_READY is high in the following cycle.
- No bypass from DONE to accept. Maximum throughput is one operation per WIDTH+2 cycles.
- Backpressure: DONE holds indefinitely while OUT_READY=0, with S/CO constant.
- No combinational path from any input to S or CO.
- Only IN_READY depends combinationally on RST.

## Structure

- **Shared package gf180mcu_fd_sc_mcu9t5v0__serial_pkg** holds:
  - the state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the localparam function for counter width.
- **Sub-module:** one instance of gf180mcu_fd_sc_mcu9t5v0__addf_1 as the bit-slice adder.
  - Port map: A←a_sr[0], B←b_sr[0], CI←carry.
  - S and CO go to the shift and carry logic.
  - VDD/VSS are passed through.
- All sequential logic stays in the top module. No other sub-modules.

## Test plan

All scenarios use WIDTH=8 unless noted.

1. A=0x3C, B=0x42, CI=0, accepted at edge k → OUT_VALID first high after edge k+8, S=0x7E, CO=0.
2. A=0xFF, B=0x01, CI=0 → S=0x00, CO=1. Then A=0xFF, B=0xFF, CI=1 → S=0xFF, CO=1.
3. Backpressure: OUT_READY=0 for 5 cycles in DONE, while IN_VALID=1 with A=0x11 → S/CO/OUT_VALID unchanged, IN_READY=0. After OUT_READY=1, the next accepted op uses the A presented at that accept edge.
4. RST=1 asserted on the 4th RUN cycle of A=0xAA+B=0x55 → next cycle state IDLE, S=0, CO=0, OUT_VALID=0. A following op 0x10+0x20, CI=0 → S=0x30, CO=0.
5. Inputs changed during RUN (A driven to 0x00 after accept of A=0x0F, B=0x01) → S=0x10, CO=0.
6. WIDTH=1 instance: A=1, B=1, CI=1 → OUT_VALID one cycle after accept, S=1, CO=1.
